// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : 640x480@60 VGA raster timing: counters, syncs, blanking, pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] c_h_active_end = 10'(H_ACTIVE - 1);
  localparam logic [9:0] c_h_front_end  = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] c_h_sync_end   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] c_h_total_end  = 10'(c_h_total - 1);
  localparam logic [9:0] c_v_active_end = 10'(V_ACTIVE - 1);
  localparam logic [9:0] c_v_front_end  = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] c_v_sync_end   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] c_v_total_end  = 10'(c_v_total - 1);

  if (c_h_total > 1024) begin : g_h_total_check
    $error("vga_timing_gen: horizontal total exceeds 1024");
  end
  if (c_v_total > 1024) begin : g_v_total_check
    $error("vga_timing_gen: vertical total exceeds 1024");
  end

  typedef enum logic [1:0] {
    REG_ACTIVE = 2'd0,
    REG_FRONT  = 2'd1,
    REG_SYNC   = 2'd2,
    REG_BACK   = 2'd3
  } region_t;

  region_t    r_h_state, w_h_next;
  region_t    r_v_state, w_v_next;
  logic [9:0] r_h, r_v;
  logic       w_h_wrap, w_v_wrap;

  always_comb begin
    w_h_wrap = (r_h == c_h_total_end);
    w_v_wrap = (r_v == c_v_total_end);
    w_h_next = r_h_state;
    w_v_next = r_v_state;
    case (r_h_state)
      REG_ACTIVE: if (r_h == c_h_active_end) w_h_next = REG_FRONT;
      REG_FRONT:  if (r_h == c_h_front_end)  w_h_next = REG_SYNC;
      REG_SYNC:   if (r_h == c_h_sync_end)   w_h_next = REG_BACK;
      REG_BACK:   if (w_h_wrap)              w_h_next = REG_ACTIVE;
      default:                               w_h_next = REG_ACTIVE;
    endcase
    // Vertical regions only move at the end of a line.
    if (w_h_wrap) begin
      case (r_v_state)
        REG_ACTIVE: if (r_v == c_v_active_end) w_v_next = REG_FRONT;
        REG_FRONT:  if (r_v == c_v_front_end)  w_v_next = REG_SYNC;
        REG_SYNC:   if (r_v == c_v_sync_end)   w_v_next = REG_BACK;
        REG_BACK:   if (w_v_wrap)              w_v_next = REG_ACTIVE;
        default:                               w_v_next = REG_ACTIVE;
      endcase
    end
  end

  // Stage 0: raster counters and region state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h       <= '0;
      r_v       <= '0;
      r_h_state <= REG_ACTIVE;
      r_v_state <= REG_ACTIVE;
    end else if (ena) begin
      r_h_state <= w_h_next;
      r_v_state <= w_v_next;
      if (w_h_wrap) begin
        r_h <= '0;
        r_v <= w_v_wrap ? 10'd0 : r_v + 10'd1;
      end else begin
        r_h <= r_h + 10'd1;
      end
    end
  end

  // Stage 1: every output registered from the same stage-0 snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      hpos        <= '0;
      vpos        <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      display_on  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ena) begin
      hpos        <= r_h;
      vpos        <= r_v;
      hsync       <= (r_h_state == REG_SYNC) ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= (r_v_state == REG_SYNC) ? VSYNC_POL : ~VSYNC_POL;
      display_on  <= (r_h_state == REG_ACTIVE) && (r_v_state == REG_ACTIVE);
      line_start  <= (r_h == 10'd0);
      frame_start <= (r_h == 10'd0) && (r_v == 10'd0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Scoreboard bench for vga_timing_gen: full-size and short-frame instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic       line_start;
    logic       frame_start;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] hpos0, vpos0, hpos1, vpos1;
  logic hs0, vs0, de0, ls0, fs0, hs1, vs1, de1, ls1, fs1;

  // Full 640x480 timing.
  vga_timing_gen dut (
    .clk(clk), .rst(rst), .ena(ena),
    .hpos(hpos0), .vpos(vpos0), .hsync(hs0), .vsync(vs0),
    .display_on(de0), .line_start(ls0), .frame_start(fs0)
  );

  // Same line timing, 11-line frame so frame wraps fit in a short run.
  vga_timing_gen #(.V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(3)) dut_s (
    .clk(clk), .rst(rst), .ena(ena),
    .hpos(hpos1), .vpos(vpos1), .hsync(hs1), .vsync(vs1),
    .display_on(de1), .line_start(ls1), .frame_start(fs1)
  );

  out_t act0, act1;
  assign act0 = {hpos0, vpos0, hs0, vs0, de0, ls0, fs0};
  assign act1 = {hpos1, vpos1, hs1, vs1, de1, ls1, fs1};

  int n_cmp = 0;
  int n_bad = 0;
  out_t q0[$];
  out_t q1[$];

  int   px[2];
  int   py[2];
  out_t last[2];
  int   v_act[2] = '{480, 4};
  int   v_fp[2]  = '{10, 2};
  int   v_syn[2] = '{2, 2};
  int   v_tot[2] = '{525, 11};

  function automatic out_t reset_out();
    out_t o;
    o = '0;
    o.hsync = 1'b1;
    o.vsync = 1'b1;
    return o;
  endfunction

  // Expected outputs for raster position (x,y): hsync low on 656..751.
  function automatic out_t decode(int x, int y, int va, int vf, int vs);
    out_t o;
    o.hpos        = 10'(x);
    o.vpos        = 10'(y);
    o.hsync       = !(x >= 656 && x < 752);
    o.vsync       = !(y >= va + vf && y < va + vf + vs);
    o.display_on  = (x < 640) && (y < va);
    o.line_start  = (x == 0);
    o.frame_start = (x == 0) && (y == 0);
    return o;
  endfunction

  task automatic step(input bit r, input bit e);
    @(negedge clk);
    rst = r;
    ena = e;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        last[i] = reset_out();
        px[i] = 0;
        py[i] = 0;
      end else if (e) begin
        last[i] = decode(px[i], py[i], v_act[i], v_fp[i], v_syn[i]);
        px[i]++;
        if (px[i] == 800) begin
          px[i] = 0;
          py[i]++;
          if (py[i] == v_tot[i]) py[i] = 0;
        end
      end
    end
    q0.push_back(last[0]);
    q1.push_back(last[1]);
  endtask

  task automatic check(input string name, input out_t a, input out_t x);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s @%0t: got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b, want h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
               name, $time, a.hpos, a.vpos, a.hsync, a.vsync, a.display_on, a.line_start, a.frame_start,
               x.hpos, x.vpos, x.hsync, x.vsync, x.display_on, x.line_start, x.frame_start);
    end
  endtask

  // Monitor: every clock presents an output cycle; compare against the queue head.
  initial begin
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check("main", act0, e);
      end
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("short", act1, e);
      end
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      px[i] = 0;
      py[i] = 0;
      last[i] = reset_out();
    end
    repeat (3) step(1'b1, 1'b1);
    // Two short frames wrap; main instance covers ~22 lines.
    repeat (18000) step(1'b0, 1'b1);
    // Freeze with hpos=300 showing, then resume at 301.
    while (px[0] != 300) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b1);
    // Mid-line reset right after hpos=400 is shown.
    while (px[0] != 400) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (1700) step(1'b0, 1'b1);
    // Reset wins over ena=0.
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b1);
    @(posedge clk);
    #2;
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d entries left, want 0/0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
